// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter and its requesters/RAM: i-side fetch, d-side load/store, RAM port, timeout flag.
// The slave modport is the arbiter's view; the master modport is the environment (requesters and RAM).
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic              ramready;
    logic              err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between instruction fetch and load/store.
// Optional MEM_ARB_TIMEOUT_EN: forces completion with all-ones data and an err pulse after TIMEOUT stalled cycles.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last_d;
    logic              r_ramREN;
    logic              r_ramWEN;
    logic [ADDR_W-1:0] r_ramaddr;
    logic [DATA_W-1:0] r_ramstore;
    logic [DATA_W-1:0] r_iload;
    logic [DATA_W-1:0] r_dload;
    logic [DATA_W-1:0] w_load;
    logic              w_dreq;
    logic              w_pick_i;
    logic              w_pick_d;
    logic              w_busy;
    logic              w_timeout;
    logic              w_done;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (w_pick_i || w_pick_d) begin
            r_cnt <= '0;
        end else if (w_busy && !bus.ramready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The stalled cycle that would bring the count up to TIMEOUT is the one that gets forced.
    assign w_timeout = w_busy && !bus.ramready && (r_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_dreq = bus.dREN | bus.dWEN;
    assign w_busy = (r_state != IDLE);
    assign w_done = w_busy && (bus.ramready || w_timeout);
    assign w_load = w_timeout ? {DATA_W{1'b1}} : bus.ramload;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_pick_i = 1'b0;
        w_pick_d = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.iREN && w_dreq) begin
                    w_pick_i = r_last_d;
                    w_pick_d = !r_last_d;
                end else begin
                    w_pick_i = bus.iREN;
                    w_pick_d = w_dreq;
                end
                if (w_pick_i)      w_next = GRANT_I;
                else if (w_pick_d) w_next = GRANT_D;
            end
            GRANT_I, GRANT_D: begin
                if (w_done) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // RAM-side registers are frozen for the whole grant; requester inputs only matter at grant time.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_last_d   <= 1'b0;
            r_ramREN   <= 1'b0;
            r_ramWEN   <= 1'b0;
            r_ramaddr  <= '0;
            r_ramstore <= '0;
            r_iload    <= '0;
            r_dload    <= '0;
        end else if (w_pick_i) begin
            r_last_d  <= 1'b0;
            r_ramREN  <= 1'b1;
            r_ramWEN  <= 1'b0;
            r_ramaddr <= bus.iaddr;
        end else if (w_pick_d) begin
            r_last_d   <= 1'b1;
            r_ramREN   <= bus.dREN && !bus.dWEN;
            r_ramWEN   <= bus.dWEN;
            r_ramaddr  <= bus.daddr;
            r_ramstore <= bus.dstore;
        end else if (w_done) begin
            r_ramREN <= 1'b0;
            r_ramWEN <= 1'b0;
            if (r_state == GRANT_I)             r_iload <= w_load;
            if (r_state == GRANT_D && r_ramREN) r_dload <= w_load;
        end
    end

    assign bus.iwait    = bus.iREN && !(r_state == GRANT_I && w_done);
    assign bus.dwait    = w_dreq && !(r_state == GRANT_D && w_done);
    assign bus.iload    = r_iload;
    assign bus.dload    = r_dload;
    assign bus.ramREN   = r_ramREN;
    assign bus.ramWEN   = r_ramWEN;
    assign bus.ramaddr  = r_ramaddr;
    assign bus.ramstore = r_ramstore;
    assign bus.err      = w_timeout;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected RAM accesses, a negedge monitor checks them.
// The timeout scenario runs only when MEM_ARB_TIMEOUT_EN is defined (instance uses TIMEOUT=4).
module tb_mem_arbiter;
    typedef struct {
        int          kind;   // 0 = I read, 1 = D read, 2 = D write
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] load;   // iload/dload value required the cycle after completion
    } acc_t;

    logic CLK = 1'b0;
    logic RST;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   exp_to  = 1'b0;
    acc_t q[$];
    logic [31:0] sh_i, sh_d;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(b)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] addr, input logic [31:0] store,
                        input logic [31:0] load);
        acc_t e;
        e.kind = kind; e.addr = addr; e.store = store; e.load = load;
        q.push_back(e);
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            if (b.ramREN || b.ramWEN) begin
                ok = 1'b1;
                return;
            end
        end
        chk("grant_wait", 32'd0, 32'd1);
    endtask

    task automatic pulse(input int extra, input logic [31:0] data);
        repeat (extra) begin @(posedge CLK); #1; end
        b.ramload  = data;
        b.ramready = 1'b1;
        @(posedge CLK); #1;
        b.ramready = 1'b0;
        b.ramload  = 32'hBAD0_0000;
        chk("idle_gap", {30'd0, b.ramREN, b.ramWEN}, 32'd0);
    endtask

    task automatic serve(input int n, input logic [31:0] data);
        bit ok;
        wait_strobe(ok);
        if (ok) pulse(n - 1, data);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ramREN", {31'd0, b.ramREN}, 32'd0);
        chk("rst_ramWEN", {31'd0, b.ramWEN}, 32'd0);
        chk("rst_ramaddr", b.ramaddr, 32'd0);
        chk("rst_ramstore", b.ramstore, 32'd0);
        chk("rst_iload", b.iload, 32'd0);
        chk("rst_dload", b.dload, 32'd0);
        chk("rst_err", {31'd0, b.err}, 32'd0);
        RST  = 1'b0;
        sh_i = 32'd0;
        sh_d = 32'd0;
        @(posedge CLK); #1;
    endtask

    // Monitor: grant contents, stability across the grant, wait/err every cycle, load after completion.
    initial begin
        bit   in_acc = 1'b0, pend = 1'b0, strobe, done;
        acc_t cur, pc;
        cur = '{0, 32'd0, 32'd0, 32'd0};
        pc  = cur;
        forever begin
            @(negedge CLK);
            strobe = b.ramREN || b.ramWEN;
            if (pend) begin
                if (pc.kind == 0) chk("iload", b.iload, pc.load);
                else              chk("dload", b.dload, pc.load);
                pend = 1'b0;
            end
            if (strobe && !in_acc) begin
                if (q.size() == 0) begin
                    chk("unexpected_grant", b.ramaddr, 32'hFFFF_FFFF);
                end else begin
                    cur    = q.pop_front();
                    in_acc = 1'b1;
                    chk("grant_addr", b.ramaddr, cur.addr);
                    chk("grant_ren", {31'd0, b.ramREN}, {31'd0, cur.kind != 2});
                    chk("grant_wen", {31'd0, b.ramWEN}, {31'd0, cur.kind == 2});
                    if (cur.kind == 2) chk("grant_store", b.ramstore, cur.store);
                end
            end else if (strobe && in_acc) begin
                chk("hold_addr", b.ramaddr, cur.addr);
                chk("hold_strobe", {30'd0, b.ramREN, b.ramWEN},
                    (cur.kind == 2) ? 32'd1 : 32'd2);
            end else if (!strobe) begin
                in_acc = 1'b0;
            end
            done = in_acc && (b.ramready || exp_to);
            chk("iwait", {31'd0, b.iwait}, {31'd0, b.iREN && !(done && cur.kind == 0)});
            chk("dwait", {31'd0, b.dwait},
                {31'd0, (b.dREN || b.dWEN) && !(done && cur.kind != 0)});
            chk("err", {31'd0, b.err}, {31'd0, exp_to});
            if (done) begin
                pend   = 1'b1;
                pc     = cur;
                in_acc = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        b.iREN = 0; b.iaddr = 0; b.dREN = 0; b.dWEN = 0; b.daddr = 0; b.dstore = 0;
        b.ramload = 0; b.ramready = 0;
        sh_i = 0; sh_d = 0;
        do_reset();

        // I only, ramready three cycles into the access
        b.iREN = 1; b.iaddr = 32'h40;
        push(0, 32'h40, 32'h0, 32'h8C22_0004);
        serve(3, 32'h8C22_0004);
        b.iREN = 0; sh_i = 32'h8C22_0004;

        // ramready while idle must be ignored
        @(posedge CLK); #1;
        b.ramready = 1; b.ramload = 32'h1234_5678;
        @(posedge CLK); #1;
        b.ramready = 0;
        chk("idle_ready_strobe", {30'd0, b.ramREN, b.ramWEN}, 32'd0);
        @(posedge CLK); #1;
        chk("idle_ready_iload", b.iload, sh_i);
        chk("idle_ready_dload", b.dload, sh_d);

        // Simultaneous requests right after reset: D first, then I
        do_reset();
        b.iREN = 1; b.dREN = 1; b.iaddr = 32'h80; b.daddr = 32'h200;
        push(1, 32'h200, 32'h0, 32'h1111_2222);
        push(0, 32'h80, 32'h0, 32'h3333_4444);
        serve(2, 32'h1111_2222);
        b.dREN = 0;
        serve(1, 32'h3333_4444);
        b.iREN = 0;

        // Three contested rounds: D, I, D, I, D, I
        b.iREN = 1; b.dREN = 1;
        for (int k = 0; k < 3; k++) begin
            b.daddr = 32'h300 + 4 * k;
            b.iaddr = 32'h500 + 4 * k;
            push(1, 32'h300 + 4 * k, 32'h0, 32'hD000_0000 + k);
            push(0, 32'h500 + 4 * k, 32'h0, 32'hA000_0000 + k);
            serve(1, 32'hD000_0000 + k);
            serve(2, 32'hA000_0000 + k);
        end
        b.iREN = 0; b.dREN = 0;
        sh_d = 32'hD000_0002; sh_i = 32'hA000_0002;

        // Write with dREN and dWEN both high, then a pure write; dload must not change
        b.dREN = 1; b.dWEN = 1; b.daddr = 32'h100; b.dstore = 32'hDEAD_BEEF;
        push(2, 32'h100, 32'hDEAD_BEEF, sh_d);
        serve(2, 32'h5555_5555);
        b.dREN = 0; b.daddr = 32'h104; b.dstore = 32'hCAFE_F00D;
        push(2, 32'h104, 32'hCAFE_F00D, sh_d);
        serve(1, 32'h6666_6666);
        b.dWEN = 0;

        // Request withdrawn after grant still completes and loads data
        b.iREN = 1; b.iaddr = 32'h60;
        push(0, 32'h60, 32'h0, 32'h0BAD_F00D);
        wait_strobe(ok);
        b.iREN = 0; b.iaddr = 32'h999;
        if (ok) pulse(1, 32'h0BAD_F00D);
        sh_i = 32'h0BAD_F00D;

        // Asynchronous reset in the middle of a D grant
        b.dREN = 1; b.daddr = 32'h140;
        push(1, 32'h140, 32'h0, 32'h7777_7777);
        wait_strobe(ok);
        @(negedge CLK); #1;
        RST = 1;
        #1;
        chk("async_rst_ramREN", {31'd0, b.ramREN}, 32'd0);
        chk("async_rst_ramWEN", {31'd0, b.ramWEN}, 32'd0);
        chk("async_rst_iload", b.iload, 32'd0);
        b.dREN = 0;
        @(posedge CLK); #1;
        RST = 0; sh_i = 0; sh_d = 0;
        @(posedge CLK); #1;
        b.ramready = 1; b.ramload = 32'h9999_9999;
        @(posedge CLK); #1;
        b.ramready = 0;
        chk("post_rst_strobe", {30'd0, b.ramREN, b.ramWEN}, 32'd0);
        @(posedge CLK); #1;
        chk("post_rst_dload", b.dload, 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
        // No ramready: forced completion on the 4th grant cycle
        b.dREN = 1; b.daddr = 32'h180;
        push(1, 32'h180, 32'h0, 32'hFFFF_FFFF);
        wait_strobe(ok);
        if (ok) begin
            repeat (3) begin @(posedge CLK); #1; end
            exp_to = 1;
            @(posedge CLK); #1;
            exp_to = 0;
            chk("timeout_idle", {30'd0, b.ramREN, b.ramWEN}, 32'd0);
        end
        b.dREN = 0;
`endif

        repeat (3) @(posedge CLK);
        #1;
        chk("queue_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one shared single-port RAM between the instruction-fetch requester (i-side) and the load/store requester (d-side) of the CPU datapath.
- Latches the winning request, drives the RAM for the whole access, and returns data plus wait status to the winner.
- Sits between the fetch/decode front end, the memory stage and the RAM model.

Parameters:
ADDR_W, 32, width of request and RAM addresses
DATA_W, 32, width of data buses
TIMEOUT, 255, max cycles a granted access waits for ramready (used only with MEM_ARB_TIMEOUT_EN)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
iREN  in  1  instruction read request
iaddr  in  ADDR_W  instruction address
iwait  out  1  instruction stall
iload  out  DATA_W  instruction read data
dREN  in  1  data read request
dWEN  in  1  data write request
daddr  in  ADDR_W  data address
dstore  in  DATA_W  data write value
dwait  out  1  data stall
dload  out  DATA_W  data read data
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data
ramready  in  1  one-cycle RAM completion pulse
err  out  1  timeout pulse; constant 0 without MEM_ARB_TIMEOUT_EN

Behaviour:
- Clock/reset: one clock CLK. RST is asynchronous, active-high; it clears all state immediately.
- Reset values:
  - FSM = IDLE; last_grant = I, so D has priority first.
  - ramREN/ramWEN = 0; ramaddr/ramstore = 0.
  - iload/dload = 0; err = 0; timeout counter = 0.
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE arbitration:
  - dreq = dREN|dWEN.
  - Only one of iREN/dreq high: grant that side.
  - Both high: grant the side opposite last_grant (round-robin).
  - Neither high: stay in IDLE.
- On grant:
  - Register address/data into ramaddr/ramstore, set ramREN/ramWEN, update last_grant.
  - Request sampled in cycle N produces RAM strobes in cycle N+1.
- Grant type:
  - GRANT_I: ramREN=1, ramWEN=0.
  - GRANT_D: ramWEN=dWEN. If dWEN and dREN are both high, it is a write: ramREN=0, ramWEN=1. Otherwise ramREN=dREN.
- RAM output stability: RAM outputs are registered and held constant for the whole grant. Requester input changes after the grant are ignored.
- Completion: ramready=1 in a GRANT state (cycle M).
  - The winner's wait is 0 in cycle M.
  - Its load output is updated at the M edge: ramload is registered into iload/dload, valid from M+1 and held until the next completion on that side. Writes leave dload unchanged.
  - FSM goes to IDLE, strobes drop at the M edge.
  - Minimum one IDLE cycle between accesses; the next grant strobes appear at M+2.
- Wait rules:
  - iwait = iREN & !(GRANT_I & ramready).
  - dwait = dreq & !(GRANT_D & ramready).
  - Wait is never asserted without a request.
- Request withdrawn mid-grant: the access still completes and the returned data is still registered. No abort is issued to the RAM.
- ramready in IDLE is ignored.
- Reset mid-access: strobes drop asynchronously, nothing is latched, and the RAM access is abandoned.

Optional Feature:
MEM_ARB_TIMEOUT_EN:
- Defined:
  - An 8-bit+ counter clears on grant and increments each GRANT cycle without ramready.
  - When the count reaches TIMEOUT, the arbiter forces completion: the winner's wait drops for that cycle, load is registered as all-ones, err pulses 1 for one cycle, and the FSM goes to IDLE.
- Undefined:
  - No counter; err is tied to 0.
  - The arbiter waits indefinitely for ramready.

Test Plan:
- I only: iREN=1, iaddr=0x40, ramready 3 cycles after ramREN -> ramREN high for 3 cycles, ramaddr=0x40, iwait low only in the ramready cycle, iload=ramload (0x8C220004) from the next cycle.
- Simultaneous after reset: iREN=dREN=1 -> D granted first. After completion, IDLE for 1 cycle, then I granted. dwait stays high until D's ramready; iwait stays high until I's ramready.
- Round-robin: three back-to-back contested rounds -> grants D, I, D, I, D, I. Starvation never exceeds one access.
- Write with dWEN=dREN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, dload unchanged.
- RST asserted mid-GRANT_D -> ramREN/ramWEN = 0 in the same cycle without a clock edge; FSM IDLE; a later ramready pulse is ignored.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=4, no ramready -> dwait drops and err=1 on the 4th wait cycle; dload=0xFFFFFFFF; FSM returns to IDLE.
